axi_mem_responder: RTL and testbench

AXI_MEM_RESPONDER -- requirements
Module: axi_mem_responder

---
 rtl/axi_resp_pkg.sv | 23 ++
 rtl/axi_burst_addr.sv | 27 ++
 rtl/axi_mem_responder.sv | 209 ++++++++++++++++++++
 tb/tb_axi_mem_responder.sv | 344 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_resp_pkg.sv
// Shared types and protocol constants for the AXI memory responder.
package axi_resp_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_R_WAIT,
        S_R_BURST,
        S_W_DATA,
        S_W_SNOOP,
        S_W_RESP
    } state_t;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam logic [3:0]  ACSNOOP_MAKE_INVALID = 4'hD;
    localparam logic [63:0] SNOOP_LINE_MASK      = ~64'h3F;

endpackage

// File: rtl/axi_burst_addr.sv
// Next beat address for FIXED / INCR / WRAP bursts of 64-bit beats.
module axi_burst_addr
    import axi_resp_pkg::*;
(
    input  logic [63:0] addr,
    input  logic [7:0]  len,
    input  logic [1:0]  burst,
    output logic [63:0] next_addr
);

    logic [63:0] w_incr;
    logic [63:0] w_wrap_mask;

    assign w_incr      = addr + 64'd8;
    // Wrap window is (len+1) beats of 8 bytes, aligned to its own size.
    assign w_wrap_mask = ((64'(len) + 64'd1) << 3) - 64'd1;

    always_comb begin
        next_addr = w_incr;
        case (burst)
            BURST_FIXED: next_addr = addr;
            BURST_WRAP:  next_addr = (addr & ~w_wrap_mask) | (w_incr & w_wrap_mask);
            default:     next_addr = w_incr;
        endcase
    end

endmodule

// File: rtl/axi_mem_responder.sv
// Single-outstanding AXI memory responder with a write-invalidate snoop
// issued on the AC channel before each write response.
module axi_mem_responder
    import axi_resp_pkg::*;
#(
    parameter int          MEM_WORDS      = 4096,
    parameter logic [63:0] BASE_ADDR      = 64'h0,
    parameter int          READ_LATENCY   = 2,
    parameter int          SNOOP_ON_WRITE = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        arvalid,
    output logic        arready,
    input  logic [63:0] araddr,
    input  logic [7:0]  arlen,
    input  logic [2:0]  arsize,
    input  logic [1:0]  arburst,
    output logic        rvalid,
    input  logic        rready,
    output logic [63:0] rdata,
    output logic        rlast,
    input  logic        awvalid,
    output logic        awready,
    input  logic [63:0] awaddr,
    input  logic [7:0]  awlen,
    input  logic [2:0]  awsize,
    input  logic [1:0]  awburst,
    input  logic        wvalid,
    output logic        wready,
    input  logic [63:0] wdata,
    input  logic [7:0]  wstrb,
    input  logic        wlast,
    output logic        bvalid,
    input  logic        bready,
    output logic [1:0]  bresp,
    output logic        acvalid,
    input  logic        acready,
    output logic [63:0] acaddr,
    output logic [3:0]  acsnoop
);

    localparam int          IDX_W    = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
    localparam int          LAT_M1   = (READ_LATENCY > 1) ? READ_LATENCY - 1 : 0;
    localparam logic [15:0] LAT_LAST = 16'(LAT_M1);

    function automatic logic [IDX_W-1:0] word_idx(input logic [63:0] a);
        logic [63:0] w_word;
        w_word = (a - BASE_ADDR) >> 3;
        return IDX_W'(w_word % 64'(MEM_WORDS));
    endfunction

    logic [63:0] r_mem [MEM_WORDS];

    state_t      r_state;
    state_t      w_next;
    logic [63:0] r_addr;
    logic [63:0] r_start_addr;
    logic [7:0]  r_len;
    logic [1:0]  r_burst;
    logic [8:0]  r_beat;
    logic [15:0] r_lat_cnt;

    logic        r_arready, r_awready, r_rvalid, r_rlast, r_wready;
    logic        r_bvalid, r_acvalid;
    logic [63:0] r_rdata, r_acaddr;
    logic [1:0]  r_bresp;
    logic [3:0]  r_acsnoop;

    logic             w_ar_hs, w_aw_hs, w_r_hs, w_w_hs, w_ac_hs, w_b_hs;
    logic             w_beat_is_last, w_beat_in_range, w_mem_we;
    logic [63:0]      w_next_addr;
    logic [IDX_W-1:0] w_rd_idx, w_wr_idx;
    logic             w_unused_size;

    assign w_unused_size = ^{arsize, awsize};

    // Write wins a simultaneous request; the read stays pending on AR.
    assign w_aw_hs = awvalid & r_awready;
    assign w_ar_hs = arvalid & r_arready & ~awvalid;
    assign w_r_hs  = r_rvalid & rready;
    assign w_w_hs  = wvalid & r_wready;
    assign w_ac_hs = r_acvalid & acready;
    assign w_b_hs  = r_bvalid & bready;

    assign w_beat_is_last  = (r_beat == {1'b0, r_len});
    assign w_beat_in_range = (r_beat <= {1'b0, r_len});
    assign w_mem_we        = w_w_hs & w_beat_in_range & ~reset;

    axi_burst_addr u_burst_addr (
        .addr      (r_addr),
        .len       (r_len),
        .burst     (r_burst),
        .next_addr (w_next_addr)
    );

    assign w_rd_idx = word_idx((r_state == S_R_BURST) ? w_next_addr : r_addr);
    assign w_wr_idx = word_idx(r_addr);

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_aw_hs)      w_next = S_W_DATA;
                else if (w_ar_hs) w_next = S_R_WAIT;
            end
            S_R_WAIT:  if (r_lat_cnt == LAT_LAST) w_next = S_R_BURST;
            S_R_BURST: if (w_r_hs && w_beat_is_last) w_next = S_IDLE;
            S_W_DATA: begin
                if (w_w_hs && wlast) w_next = (SNOOP_ON_WRITE != 0) ? S_W_SNOOP : S_W_RESP;
            end
            S_W_SNOOP: if (w_ac_hs) w_next = S_W_RESP;
            S_W_RESP:  if (w_b_hs) w_next = S_IDLE;
            default:   w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_arready <= 1'b0;
            r_awready <= 1'b0;
            r_rvalid  <= 1'b0;
            r_rlast   <= 1'b0;
            r_wready  <= 1'b0;
            r_bvalid  <= 1'b0;
            r_acvalid <= 1'b0;
            r_rdata   <= 64'h0;
            r_bresp   <= 2'b00;
            r_acaddr  <= 64'h0;
            r_acsnoop <= 4'h0;
            r_beat    <= 9'd0;
            r_lat_cnt <= 16'd0;
        end else begin
            r_state   <= w_next;
            r_arready <= (w_next == S_IDLE);
            r_awready <= (w_next == S_IDLE);
            r_rvalid  <= (w_next == S_R_BURST);
            r_wready  <= (w_next == S_W_DATA);
            r_acvalid <= (w_next == S_W_SNOOP);
            r_bvalid  <= (w_next == S_W_RESP);
            r_lat_cnt <= (r_state == S_R_WAIT) ? r_lat_cnt + 16'd1 : 16'd0;

            // Excess write beats past awlen leave the counter at len+1.
            if (w_aw_hs || w_ar_hs)
                r_beat <= 9'd0;
            else if (w_r_hs || (w_w_hs && w_beat_in_range))
                r_beat <= r_beat + 9'd1;

            if (r_state == S_R_WAIT && w_next == S_R_BURST) begin
                r_rdata <= r_mem[w_rd_idx];
                r_rlast <= (r_len == 8'd0);
            end else if (w_r_hs) begin
                if (w_beat_is_last) begin
                    r_rlast <= 1'b0;
                end else begin
                    r_rdata <= r_mem[w_rd_idx];
                    r_rlast <= ((r_beat + 9'd1) == {1'b0, r_len});
                end
            end

            if (w_w_hs && wlast)
                r_bresp <= w_beat_is_last ? RESP_OKAY : RESP_SLVERR;

            if (r_state == S_W_DATA && w_next == S_W_SNOOP) begin
                r_acaddr  <= r_start_addr & SNOOP_LINE_MASK;
                r_acsnoop <= ACSNOOP_MAKE_INVALID;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_aw_hs) begin
            r_addr       <= awaddr;
            r_start_addr <= awaddr;
            r_len        <= awlen;
            r_burst      <= awburst;
        end else if (w_ar_hs) begin
            r_addr       <= araddr;
            r_start_addr <= araddr;
            r_len        <= arlen;
            r_burst      <= arburst;
        end else if (w_r_hs || (w_w_hs && w_beat_in_range)) begin
            r_addr       <= w_next_addr;
        end
    end

    // Byte-lane write; the array has no reset so data survives a reset.
    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            for (int b = 0; b < 8; b++) begin
                if (wstrb[b]) r_mem[w_wr_idx][b*8 +: 8] <= wdata[b*8 +: 8];
            end
        end
    end

    assign arready = r_arready;
    assign awready = r_awready;
    assign rvalid  = r_rvalid;
    assign rdata   = r_rdata;
    assign rlast   = r_rlast;
    assign wready  = r_wready;
    assign bvalid  = r_bvalid;
    assign bresp   = r_bresp;
    assign acvalid = r_acvalid;
    assign acaddr  = r_acaddr;
    assign acsnoop = r_acsnoop;

endmodule

// File: tb/tb_axi_mem_responder.sv
// Self-checking bench for axi_mem_responder: table of read/write bursts plus
// hand sequences for snoop, error responses, request collision and reset.
module tb_axi_mem_responder;

    localparam int MEM_WORDS = 4096;
    localparam int LAT       = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        arvalid, arready, rvalid, rready, rlast;
    logic [63:0] araddr, rdata;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic        awvalid, awready, wvalid, wready, wlast, bvalid, bready;
    logic [63:0] awaddr, wdata;
    logic [7:0]  awlen, wstrb;
    logic [2:0]  awsize;
    logic [1:0]  awburst, bresp;
    logic        acvalid, acready;
    logic [63:0] acaddr;
    logic [3:0]  acsnoop;

    axi_mem_responder #(
        .MEM_WORDS      (MEM_WORDS),
        .BASE_ADDR      (64'h0),
        .READ_LATENCY   (LAT),
        .SNOOP_ON_WRITE (1)
    ) dut (
        .clk(clk), .reset(reset),
        .arvalid(arvalid), .arready(arready), .araddr(araddr), .arlen(arlen),
        .arsize(arsize), .arburst(arburst),
        .rvalid(rvalid), .rready(rready), .rdata(rdata), .rlast(rlast),
        .awvalid(awvalid), .awready(awready), .awaddr(awaddr), .awlen(awlen),
        .awsize(awsize), .awburst(awburst),
        .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
        .bvalid(bvalid), .bready(bready), .bresp(bresp),
        .acvalid(acvalid), .acready(acready), .acaddr(acaddr), .acsnoop(acsnoop)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [63:0] exp_q [$];
    logic [63:0] mdl [int];
    logic [63:0] wd [64];
    logic [7:0]  ws [64];

    typedef struct {
        bit          wr;
        logic [63:0] addr;
        logic [7:0]  len;
        logic [1:0]  burst;
        int          nbeats;
        logic [7:0]  strb;
        logic [1:0]  exp_bresp;
    } op_t;

    op_t ops [10];

    function automatic int m_idx(input logic [63:0] a);
        logic [63:0] w = a / 64'd8;
        return int'(w % 64'(MEM_WORDS));
    endfunction

    function automatic logic [63:0] m_next(input logic [63:0] a, input logic [7:0] len,
                                           input logic [1:0] burst);
        logic [63:0] span, base;
        if (burst == 2'b00) return a;
        if (burst == 2'b10) begin
            span = (64'(len) + 64'd1) * 64'd8;
            base = a - (a % span);
            return base + ((a - base + 64'd8) % span);
        end
        return a + 64'd8;
    endfunction

    function automatic void m_write(input logic [63:0] a, input logic [63:0] d, input logic [7:0] s);
        int          i   = m_idx(a);
        logic [63:0] cur = mdl.exists(i) ? mdl[i] : 64'h0;
        for (int b = 0; b < 8; b++)
            if (s[b]) cur[b*8 +: 8] = d[b*8 +: 8];
        mdl[i] = cur;
    endfunction

    function automatic logic [63:0] m_read(input logic [63:0] a);
        int i = m_idx(a);
        return mdl.exists(i) ? mdl[i] : 64'hDEAD_0000_0000_0000;
    endfunction

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic tmo(input string nm);
        n_checks++;
        n_fail++;
        $display("FAIL %s: timeout, got no DUT response, expected one within the cycle bound", nm);
    endtask

    task automatic ar_send(input logic [63:0] a, input logic [7:0] len, input logic [1:0] burst);
        int g = 0;
        @(negedge clk);
        arvalid = 1'b1; araddr = a; arlen = len; arburst = burst; arsize = 3'd3;
        while (!arready && g < 100) begin @(negedge clk); g++; end
        if (g >= 100) tmo("ar_accept");
        @(posedge clk); #1;
        arvalid = 1'b0;
    endtask

    task automatic aw_send(input logic [63:0] a, input logic [7:0] len, input logic [1:0] burst);
        int g = 0;
        @(negedge clk);
        awvalid = 1'b1; awaddr = a; awlen = len; awburst = burst; awsize = 3'd3;
        while (!awready && g < 100) begin @(negedge clk); g++; end
        if (g >= 100) tmo("aw_accept");
        @(posedge clk); #1;
        awvalid = 1'b0;
    endtask

    // Collects len+1 beats against the scoreboard; returns cycles from accept to first rvalid.
    task automatic read_collect(input logic [7:0] len, input bit stall, output int lat);
        int beats = 0;
        int cyc   = 0;
        lat = -1;
        while (beats <= int'(len) && cyc < 400) begin
            @(negedge clk); cyc++;
            if (rvalid) begin
                if (lat < 0) lat = cyc - 1;
                if (exp_q.size() == 0) begin
                    tmo("scoreboard_empty");
                    beats = 999;
                end else if (stall && (cyc % 3 == 0)) begin
                    rready = 1'b0;
                    check("rdata_hold", rdata, exp_q[0]);
                end else begin
                    rready = 1'b1;
                    check("rdata", rdata, exp_q.pop_front());
                    check("rlast", 64'(rlast), 64'(beats == int'(len)));
                    beats++;
                end
            end else begin
                rready = 1'b0;
            end
        end
        if (cyc >= 400) tmo("read_beats");
        @(negedge clk);
        rready = 1'b0;
        check("rvalid_after_last", 64'(rvalid), 64'd0);
    endtask

    task automatic do_read(input logic [63:0] a, input logic [7:0] len, input logic [1:0] burst,
                           input bit stall, output int lat);
        logic [63:0] p = a;
        for (int k = 0; k <= int'(len); k++) begin
            exp_q.push_back(m_read(p));
            p = m_next(p, len, burst);
        end
        ar_send(a, len, burst);
        read_collect(len, stall, lat);
    endtask

    task automatic do_write(input logic [63:0] a, input logic [7:0] len, input logic [1:0] burst,
                            input int nbeats, input bit skip_aw, input int ac_delay,
                            input int b_delay, input logic [1:0] exp_bresp);
        logic [63:0] p = a;
        int g;
        if (!skip_aw) aw_send(a, len, burst);
        for (int k = 0; k < nbeats; k++) begin
            @(negedge clk);
            wvalid = 1'b1; wdata = wd[k]; wstrb = ws[k]; wlast = (k == nbeats - 1);
            g = 0;
            while (!wready && g < 100) begin @(negedge clk); g++; end
            if (g >= 100) tmo("wready");
            if (k <= int'(len)) begin
                m_write(p, wd[k], ws[k]);
                p = m_next(p, len, burst);
            end
            @(posedge clk); #1;
        end
        wvalid = 1'b0; wlast = 1'b0;
        @(negedge clk);
        check("wready_after_wlast", 64'(wready), 64'd0);
        g = 0;
        while (!acvalid && g < 50) begin @(negedge clk); g++; end
        if (g >= 50) tmo("acvalid");
        check("acaddr", acaddr, a & ~64'h3F);
        check("acsnoop", 64'(acsnoop), 64'hD);
        for (int d = 0; d < ac_delay; d++) begin
            check("bvalid_before_acready", 64'(bvalid), 64'd0);
            check("acvalid_held", 64'(acvalid), 64'd1);
            @(negedge clk);
        end
        acready = 1'b1;
        @(posedge clk); #1;
        acready = 1'b0;
        g = 0;
        @(negedge clk);
        while (!bvalid && g < 50) begin @(negedge clk); g++; end
        if (g >= 50) tmo("bvalid");
        for (int d = 0; d < b_delay; d++) begin
            check("bresp_held", 64'(bresp), 64'(exp_bresp));
            @(negedge clk);
        end
        check("bresp", 64'(bresp), 64'(exp_bresp));
        bready = 1'b1;
        @(posedge clk); #1;
        bready = 1'b0;
        @(negedge clk);
        check("bvalid_after_bready", 64'(bvalid), 64'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, expected completion within time bound");
        $fatal(1);
    end

    initial begin
        int lat;
        int g;
        reset = 1'b1;
        arvalid = 0; araddr = 0; arlen = 0; arsize = 0; arburst = 0; rready = 0;
        awvalid = 0; awaddr = 0; awlen = 0; awsize = 0; awburst = 0;
        wvalid = 0; wdata = 0; wstrb = 0; wlast = 0; bready = 0; acready = 0;

        ops[0] = '{1'b0, 64'h000,  8'd0, 2'b01, 1, 8'h00, 2'b00};
        ops[1] = '{1'b0, 64'h040,  8'd2, 2'b00, 3, 8'h00, 2'b00};
        ops[2] = '{1'b1, 64'h200,  8'd3, 2'b11, 4, 8'hFF, 2'b00};
        ops[3] = '{1'b0, 64'h200,  8'd3, 2'b01, 4, 8'h00, 2'b00};
        ops[4] = '{1'b1, 64'h038,  8'd1, 2'b10, 2, 8'hF0, 2'b00};
        ops[5] = '{1'b0, 64'h038,  8'd1, 2'b10, 2, 8'h00, 2'b00};
        ops[6] = '{1'b1, 64'h080,  8'd2, 2'b00, 3, 8'h01, 2'b00};
        ops[7] = '{1'b0, 64'h078,  8'd2, 2'b01, 3, 8'h00, 2'b00};
        ops[8] = '{1'b1, 64'h7FF8, 8'd1, 2'b01, 2, 8'hFF, 2'b00};
        ops[9] = '{1'b0, 64'h7FF8, 8'd1, 2'b01, 2, 8'h00, 2'b00};

        repeat (3) @(negedge clk);
        check("rst_arready", 64'(arready), 64'd0);
        check("rst_awready", 64'(awready), 64'd0);
        check("rst_rvalid",  64'(rvalid),  64'd0);
        check("rst_rlast",   64'(rlast),   64'd0);
        check("rst_wready",  64'(wready),  64'd0);
        check("rst_bvalid",  64'(bvalid),  64'd0);
        check("rst_acvalid", 64'(acvalid), 64'd0);
        check("rst_rdata",   rdata,        64'd0);
        check("rst_bresp",   64'(bresp),   64'd0);
        check("rst_acaddr",  acaddr,       64'd0);
        check("rst_acsnoop", 64'(acsnoop), 64'd0);
        reset = 1'b0;
        @(negedge clk);
        check("post_rst_arready", 64'(arready), 64'd1);
        check("post_rst_awready", 64'(awready), 64'd1);

        // Preload word i with value i for the first 64 words.
        for (int i = 0; i < 64; i++) begin wd[i] = 64'(i); ws[i] = 8'hFF; end
        do_write(64'h0, 8'd63, 2'b01, 64, 1'b0, 0, 0, 2'b00);

        do_read(64'h100, 8'd3, 2'b01, 1'b0, lat);
        check("read_latency", 64'(lat), 64'(LAT));
        do_read(64'h118, 8'd3, 2'b10, 1'b1, lat);

        for (int i = 0; i < 10; i++) begin
            if (ops[i].wr) begin
                for (int k = 0; k < ops[i].nbeats; k++) begin
                    wd[k] = 64'hC0DE_0000_0000_0000 + (64'(i) << 16) + 64'(k);
                    ws[k] = ops[i].strb;
                end
                do_write(ops[i].addr, ops[i].len, ops[i].burst, ops[i].nbeats, 1'b0, 1, 0,
                         ops[i].exp_bresp);
            end else begin
                do_read(ops[i].addr, ops[i].len, ops[i].burst, bit'(i % 2), lat);
            end
        end

        // Partial-strobe merge with a delayed snoop acknowledge.
        wd[0] = 64'h1111_2222_3333_4444; wd[1] = 64'h5555_6666_7777_8888;
        ws[0] = 8'hFF; ws[1] = 8'hFF;
        do_write(64'h1008, 8'd1, 2'b01, 2, 1'b0, 0, 0, 2'b00);
        wd[0] = 64'hAAAA_BBBB_CCCC_DDDD; wd[1] = 64'h0123_4567_89AB_CDEF;
        ws[0] = 8'h0F; ws[1] = 8'hFF;
        do_write(64'h1008, 8'd1, 2'b01, 2, 1'b0, 3, 2, 2'b00);
        do_read(64'h1008, 8'd1, 2'b01, 1'b0, lat);

        // Early wlast: two of four beats written, SLVERR.
        for (int k = 0; k < 4; k++) begin wd[k] = 64'hE000_0000_0000_0040 + 64'(k); ws[k] = 8'hFF; end
        do_write(64'h400, 8'd3, 2'b01, 2, 1'b0, 0, 0, 2'b10);
        do_read(64'h400, 8'd1, 2'b01, 1'b0, lat);

        // Beats past awlen are dropped until wlast.
        wd[0] = 64'h5150_0000_0000_0001; wd[1] = 64'h5150_0000_0000_0002;
        do_write(64'h510, 8'd1, 2'b01, 2, 1'b0, 0, 0, 2'b00);
        for (int k = 0; k < 4; k++) begin wd[k] = 64'hEEEE_0000_0000_0500 + 64'(k); ws[k] = 8'hFF; end
        do_write(64'h500, 8'd1, 2'b01, 4, 1'b0, 0, 0, 2'b10);
        do_read(64'h500, 8'd3, 2'b01, 1'b0, lat);

        // AR and AW together: write first, read sees the new data.
        wd[0] = 64'h3003_3003_ABCD_0001; ws[0] = 8'hFF;
        @(negedge clk);
        arvalid = 1'b1; araddr = 64'h300; arlen = 8'd0; arburst = 2'b01; arsize = 3'd3;
        awvalid = 1'b1; awaddr = 64'h300; awlen = 8'd0; awburst = 2'b01; awsize = 3'd3;
        check("collide_arready", 64'(arready), 64'd1);
        check("collide_awready", 64'(awready), 64'd1);
        @(posedge clk); #1;
        awvalid = 1'b0;
        @(negedge clk);
        check("collide_ar_blocked", 64'(arready), 64'd0);
        check("collide_wready", 64'(wready), 64'd1);
        do_write(64'h300, 8'd0, 2'b01, 1, 1'b1, 0, 0, 2'b00);
        check("collide_ar_ready_again", 64'(arready), 64'd1);
        exp_q.push_back(m_read(64'h300));
        @(posedge clk); #1;
        arvalid = 1'b0;
        read_collect(8'd0, 1'b0, lat);

        // Reset while a read burst is stalled.
        ar_send(64'h100, 8'd3, 2'b01);
        rready = 1'b0;
        g = 0;
        @(negedge clk);
        while (!rvalid && g < 50) begin @(negedge clk); g++; end
        if (g >= 50) tmo("rvalid_before_reset");
        reset = 1'b1;
        @(negedge clk);
        check("midrst_rvalid", 64'(rvalid), 64'd0);
        check("midrst_arready", 64'(arready), 64'd0);
        check("midrst_rdata", rdata, 64'd0);
        reset = 1'b0;
        @(negedge clk);
        check("midrst_release_arready", 64'(arready), 64'd1);
        check("midrst_release_awready", 64'(awready), 64'd1);
        do_read(64'h100, 8'd1, 2'b01, 1'b0, lat);
        do_read(64'h1008, 8'd0, 2'b01, 1'b0, lat);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
